fsk_phase_modulator: RTL and testbench

Parametrised successor to the single-tone backscatter modulator. While `trigger_signal` is high it emits a square-wave frequency-shift carrier on `output_signal`, with a runtime-programmable half-period. It first sends an unmodulated preamble. After that it applies per-symbol 180° phase flips (codeword translation) from a bit stream delivered over a valid/ready handshake. It sits between the packet-detect logic (source of `trigger_signal`) and the RF switch pin.

---
 rtl/fsk_phase_modulator_pkg.sv | 21 ++
 rtl/carrier_div.sv | 54 +++++
 rtl/fsk_phase_modulator.sv | 159 +++++++++++++++
 tb/tb_fsk_phase_modulator.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_phase_modulator_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fsk_phase_modulator_pkg: FSM state encoding and default sizing        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package fsk_phase_modulator_pkg;

    localparam int DEFAULT_DIV_W         = 8;
    localparam int DEFAULT_SYMBOL_CLKS   = 50;
    localparam int DEFAULT_PREAMBLE_SYMS = 2;
    localparam int DEFAULT_SYM_W         = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DRAIN    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/carrier_div.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | carrier_div: half-period counter and carrier toggle flop              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module carrier_div #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             enable,
    input  logic [DIV_W-1:0] hp,
    output logic             carrier
);

    logic [DIV_W-1:0] count_q, count_d;
    logic             carrier_q, carrier_d;

    always_comb begin
        count_d   = count_q;
        carrier_d = carrier_q;
        if (clear) begin
            count_d   = '0;
            carrier_d = 1'b0;
        end else if (load) begin
            count_d   = '0;
            carrier_d = 1'b1;
        end else if (enable) begin
            if (count_q == hp - DIV_W'(1)) begin
                count_d   = '0;
                carrier_d = ~carrier_q;
            end else begin
                count_d = count_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            carrier_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            carrier_q <= carrier_d;
        end
    end

    // Look-ahead value so the parent can register its pin in the same edge.
    assign carrier = carrier_d;

endmodule
`default_nettype wire

// File: rtl/fsk_phase_modulator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fsk_phase_modulator: square-wave carrier with preamble and per-symbol |
// | 180-degree phase flips fed by a valid/ready bit stream. Rev 1.0       |
// +-----------------------------------------------------------------------+
module fsk_phase_modulator
    import fsk_phase_modulator_pkg::*;
#(
    parameter int DIV_W         = DEFAULT_DIV_W,
    parameter int SYMBOL_CLKS   = DEFAULT_SYMBOL_CLKS,
    parameter int PREAMBLE_SYMS = DEFAULT_PREAMBLE_SYMS,
    parameter int SYM_W         = DEFAULT_SYM_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             trigger_signal,
    input  logic [DIV_W-1:0] half_period,
    input  logic             bit_data,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             output_signal,
    output logic             busy,
    output logic             underflow
);

    localparam int               IDX_W    = $clog2(PREAMBLE_SYMS + 1);
    localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOL_CLKS - 1);
    localparam logic [IDX_W-1:0] IDX_PRE  = IDX_W'(PREAMBLE_SYMS - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PREAMBLE_SYMS);

    state_t           state_q, state_d;
    logic             trig_q;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [IDX_W-1:0] sym_idx_q, sym_idx_d;
    logic             phase_q, phase_d;
    logic             underflow_q, underflow_d;
    logic             out_q, out_d;

    logic             rise;
    logic             sym_wrap;
    logic             ready;
    logic             div_load;
    logic             div_clear;
    logic             div_enable;
    logic             carrier_nxt;

    assign rise       = trigger_signal & ~trig_q;
    assign sym_wrap   = (sym_cnt_q == SYM_LAST);
    assign ready      = sym_wrap && ((state_q == ST_DATA) ||
                        ((state_q == ST_PREAMBLE) && (sym_idx_q == IDX_PRE)));
    assign div_load   = (state_q == ST_IDLE) && rise;
    assign div_clear  = (state_q == ST_DRAIN) && sym_wrap;
    assign div_enable = (state_q != ST_IDLE);

    carrier_div #(
        .DIV_W (DIV_W)
    ) u_carrier_div (
        .clock   (clock),
        .reset   (reset),
        .load    (div_load),
        .clear   (div_clear),
        .enable  (div_enable),
        .hp      (hp_q),
        .carrier (carrier_nxt)
    );

    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        sym_cnt_d   = sym_cnt_q;
        sym_idx_d   = sym_idx_q;
        phase_d     = phase_q;
        underflow_d = underflow_q;

        if (state_q != ST_IDLE) begin
            if (sym_wrap) begin
                sym_cnt_d = '0;
                if (sym_idx_q != IDX_MAX) begin
                    sym_idx_d = sym_idx_q + IDX_W'(1);
                end
            end else begin
                sym_cnt_d = sym_cnt_q + SYM_W'(1);
            end
        end

        // A missing bit falls back to normal phase and latches the error.
        if (ready) begin
            phase_d = bit_valid & bit_data;
            if (!bit_valid) begin
                underflow_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d     = ST_PREAMBLE;
                    hp_d        = (half_period == '0) ? DIV_W'(1) : half_period;
                    sym_cnt_d   = '0;
                    sym_idx_d   = '0;
                    phase_d     = 1'b0;
                    underflow_d = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                if (!trigger_signal) begin
                    state_d = ST_DRAIN;
                end else if (sym_wrap && (sym_idx_q == IDX_PRE)) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (!trigger_signal) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sym_wrap) begin
                    state_d   = ST_IDLE;
                    phase_d   = 1'b0;
                    sym_idx_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_d = (state_d != ST_IDLE) & (carrier_nxt ^ phase_d);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            trig_q      <= 1'b0;
            hp_q        <= '0;
            sym_cnt_q   <= '0;
            sym_idx_q   <= '0;
            phase_q     <= 1'b0;
            underflow_q <= 1'b0;
            out_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            trig_q      <= trigger_signal;
            hp_q        <= hp_d;
            sym_cnt_q   <= sym_cnt_d;
            sym_idx_q   <= sym_idx_d;
            phase_q     <= phase_d;
            underflow_q <= underflow_d;
            out_q       <= out_d;
        end
    end

    assign bit_ready     = ready;
    assign output_signal = out_q;
    assign busy          = (state_q != ST_IDLE);
    assign underflow     = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fsk_phase_modulator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fsk_phase_modulator: frame-level reference model vs DUT            |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fsk_phase_modulator;

    localparam int SC  = 50;
    localparam int PRE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       trigger = 1'b0;
    logic [7:0] half_period = 8'd5;
    logic       bit_data = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       out_sig;
    logic       busy;
    logic       underflow;

    always #5 clk = ~clk;

    fsk_phase_modulator dut (
        .clock          (clk),
        .reset          (rst_n),
        .trigger_signal (trigger),
        .half_period    (half_period),
        .bit_data       (bit_data),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .output_signal  (out_sig),
        .busy           (busy),
        .underflow      (underflow)
    );

    int checks = 0;
    int passes = 0;

    // Frame model: t counts clocks since frame start; carrier and symbol
    // position follow from plain division of t.
    bit m_active = 0, m_drain = 0, m_phase = 0, m_uf = 0, m_trig_prev = 0;
    int m_t = 0, m_end = 0, m_hp = 1;
    int mode = 0;
    bit bits_q[$];

    function automatic logic [3:0] model_outputs();
        logic o, r;
        o = m_active && ((((m_t / m_hp) % 2) == 0) != m_phase);
        r = m_active && !m_drain && ((m_t % SC) == SC - 1) && ((m_t / SC) >= PRE - 1);
        return {o, logic'(m_active), r, logic'(m_uf)};
    endfunction

    task automatic model_reset();
        m_active = 0; m_drain = 0; m_phase = 0; m_uf = 0; m_trig_prev = 0;
    endtask

    task automatic model_step();
        logic [3:0] e;
        e = model_outputs();
        if (!m_active) begin
            if (trigger && !m_trig_prev) begin
                m_active = 1; m_drain = 0; m_t = 0; m_phase = 0; m_uf = 0;
                m_hp = (half_period == 0) ? 1 : int'(half_period);
            end
        end else begin
            if (e[1]) begin
                if (bit_valid) begin
                    m_phase = bit_data;
                    if (mode == 0 && bits_q.size() > 0) bits_q.delete(0);
                end else begin
                    m_phase = 0;
                    m_uf = 1;
                end
            end
            if (m_drain) begin
                if (m_t == m_end) begin
                    m_active = 0;
                    m_phase = 0;
                end
            end else if (!trigger) begin
                m_drain = 1;
                m_end = (m_t / SC) * SC + SC - 1;
                if ((m_t % SC) == SC - 1) m_end += SC;
            end
            m_t++;
        end
        m_trig_prev = trigger;
    endtask

    // Drive bit inputs, let the model see the same values the DUT samples,
    // then stop 1 ns after the active edge.
    task automatic tick();
        case (mode)
            0: begin
                bit_valid = (bits_q.size() > 0);
                bit_data  = bit_valid ? bits_q[0] : 1'b0;
            end
            1: begin
                bit_valid = ($urandom_range(0, 3) != 0);
                bit_data  = 1'($urandom_range(0, 1));
            end
            default: begin
                bit_valid = 1'b0;
                bit_data  = 1'($urandom_range(0, 1));
            end
        endcase
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_sig, busy, bit_ready, underflow} !== 4'b0000)
            $display("FAIL reset_async got=%b want=0000", {out_sig, busy, bit_ready, underflow});
        else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL reset_idle clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
    endtask

    task automatic test_basic_frame();
        int busy_cnt = 0;
        logic o100, o150, o200;
        mode = 0; half_period = 8'd5;
        bits_q = '{1'b1, 1'b0, 1'b1};
        trigger = 1'b1;
        for (int k = 0; k < 360; k++) begin
            if (k == 300) trigger = 1'b0;
            tick();
            if (busy) busy_cnt++;
            if (k == 100) o100 = out_sig;
            if (k == 150) o150 = out_sig;
            if (k == 200) o200 = out_sig;
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL basic clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        checks++;
        if (busy_cnt !== 350) $display("FAIL basic_busy_len got=%0d want=350", busy_cnt);
        else passes++;
        checks++;
        if ({o100, o150, o200} !== 3'b010) $display("FAIL basic_phase got=%b want=010", {o100, o150, o200});
        else passes++;
    endtask

    task automatic test_underflow();
        logic u99, u100;
        mode = 2; half_period = 8'd3; trigger = 1'b1;
        for (int k = 0; k < 260; k++) begin
            if (k == 150) trigger = 1'b0;
            tick();
            if (k == 99) u99 = underflow;
            if (k == 100) u100 = underflow;
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL underflow clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        checks++;
        if ({u99, u100} !== 2'b01) $display("FAIL underflow_onset got=%b want=01", {u99, u100});
        else passes++;
        trigger = 1'b1;
        tick();
        checks++;
        if (underflow !== 1'b0) $display("FAIL underflow_clear got=%b want=0", underflow);
        else passes++;
        trigger = 1'b0;
        for (int k = 1; k < 60; k++) begin
            tick();
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL underflow2 clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
    endtask

    task automatic test_half_period();
        logic o10, o11, o50;
        mode = 1; half_period = 8'd0; trigger = 1'b1;
        for (int k = 0; k < 80; k++) begin
            if (k == 20) trigger = 1'b0;
            tick();
            if (k == 10) o10 = out_sig;
            if (k == 11) o11 = out_sig;
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL hp0 clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        checks++;
        if ({o10, o11} !== 2'b10) $display("FAIL hp0_rate got=%b want=10", {o10, o11});
        else passes++;
        half_period = 8'd5; trigger = 1'b1;
        for (int k = 0; k < 220; k++) begin
            if (k == 10) half_period = 8'd9;
            if (k == 100) trigger = 1'b0;
            tick();
            if (k == 50) o50 = out_sig;
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL hp_change clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        checks++;
        if (o50 !== 1'b1) $display("FAIL hp_latched got=%b want=1", o50);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        mode = 1; half_period = 8'($urandom_range(1, 10)); trigger = 1'b1;
        for (int k = 0; k < 121; k++) begin
            tick();
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL rst_mid clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_sig, busy, bit_ready, underflow} !== 4'b0000)
            $display("FAIL rst_mid_async got=%b want=0000", {out_sig, busy, bit_ready, underflow});
        else passes++;
        model_reset();
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 180; k++) begin
            if (k == 3) trigger = 1'b1;
            if (k == 115) trigger = 1'b0;
            tick();
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL rst_restart clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
    endtask

    task automatic test_boundary_drop();
        logic r149, b199, b200;
        mode = 0; half_period = 8'd4;
        bits_q = '{1'b1, 1'b1};
        trigger = 1'b1;
        for (int k = 0; k < 215; k++) begin
            if (k == 150) trigger = 1'b0;
            if (k == 160) trigger = 1'b1;
            if (k == 165) trigger = 1'b0;
            tick();
            if (k == 149) r149 = bit_ready;
            if (k == 199) b199 = busy;
            if (k == 200) b200 = busy;
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL boundary clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        checks++;
        if ({r149, b199, b200} !== 3'b110) $display("FAIL boundary_drain got=%b want=110", {r149, b199, b200});
        else passes++;
    endtask

    task automatic test_back_to_back();
        mode = 1; half_period = 8'd2; trigger = 1'b1;
        for (int k = 0; k < 195; k++) begin
            if (k == 130) trigger = 1'b0;
            if (k == 135) trigger = 1'b1;
            tick();
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL b2b clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL b2b_no_restart got=%b want=0", busy);
        else passes++;
        trigger = 1'b0;
        repeat (2) tick();
        trigger = 1'b1;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL b2b_restart got=%b want=1", busy);
        else passes++;
        trigger = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            checks++;
            if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                $display("FAIL b2b_tail clk=%0d got=%b want=%b", k, {out_sig, busy, bit_ready, underflow}, model_outputs());
            else passes++;
        end
    endtask

    task automatic test_random();
        int hi, lo;
        mode = 1;
        for (int f = 0; f < 4; f++) begin
            half_period = 8'($urandom_range(0, 15));
            hi = $urandom_range(20, 300);
            lo = $urandom_range(105, 130);
            trigger = 1'b1;
            for (int k = 0; k < hi + lo; k++) begin
                if (k == hi) trigger = 1'b0;
                if (k == 30) half_period = 8'($urandom_range(0, 15));
                tick();
                checks++;
                if ({out_sig, busy, bit_ready, underflow} !== model_outputs())
                    $display("FAIL random f=%0d clk=%0d got=%b want=%b", f, k, {out_sig, busy, bit_ready, underflow}, model_outputs());
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underflow();
        test_half_period();
        test_reset_mid_frame();
        test_boundary_drop();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
